pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush scheduler for the 5-stage MIPS pipeline. It merges four sources into one set of per-stage hold and bubble controls: load-use hazard, multi-cycle divide in EX, data-memory wait in MEM, and exception flush. It also sequences the iterative divider with a start pulse, a fixed-latency counter and a result-valid strobe.

Parameters:
DIV_CYCLES, 32, cycles the divider needs after div_start; legal range 2..2^CNT_WIDTH-1.
CNT_WIDTH, 6, width of the divide countdown counter.
PERF_WIDTH, 32, width of the performance counters (see STALL_PERF_EN).

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
flush_req  in  1  exception/eret flush request from MEM
mem_busy_MEM  in  1  data memory not ready; MEM stage must wait
div_req_EX  in  1  level: a div/divu instruction occupies EX
load_use_ID  in  1  load-use hazard detected for the instruction in ID
div_start  out  1  one-cycle start pulse to the divider
div_result_valid  out  1  divider result may be consumed by EX this cycle
is_hold_IF  out  1  freeze PC
is_hold_IF_ID  out  1  freeze IF/ID register
is_hold_ID_EX  out  1  freeze ID/EX register
is_hold_EX_MEM  out  1  freeze EX/MEM register
is_zeros_IF_ID  out  1  load bubble into IF/ID
is_zeros_ID_EX  out  1  load bubble into ID/EX
is_zeros_EX_MEM  out  1  load bubble into EX/MEM
is_zeros_MEM_WB  out  1  load bubble into MEM/WB
perf_clr  in  1  synchronous clear of perf counters
stall_cycles  out  PERF_WIDTH  cycles with is_hold_IF asserted
flush_count  out  PERF_WIDTH  number of flush_req cycles

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, all outputs 0.
- All controls are active-high. Controls are combinational from state and current inputs, so a stall takes effect in the cycle its cause appears. State and counter are registered on posedge clk.
- States:
  - IDLE: no divide in flight.
  - DIV_BUSY: divider running, counter live.
  - DIV_DONE: result ready, waiting for EX to advance.
- Priority, highest first. Exactly one row drives the controls each cycle:
  1. flush_req=1:
     - is_zeros_IF_ID, is_zeros_ID_EX, is_zeros_EX_MEM = 1; all holds 0; div_start 0.
     - Next state IDLE, counter cleared; any in-flight divide is abandoned.
  2. mem_busy_MEM=1:
     - is_hold_IF, is_hold_IF_ID, is_hold_ID_EX, is_hold_EX_MEM = 1; is_zeros_MEM_WB = 1.
  3. Divide stall (state DIV_BUSY, or state IDLE with div_req_EX=1):
     - is_hold_IF, is_hold_IF_ID, is_hold_ID_EX = 1; is_zeros_EX_MEM = 1.
  4. load_use_ID=1 (state IDLE or DIV_DONE):
     - is_hold_IF, is_hold_IF_ID = 1; is_zeros_ID_EX = 1.
  5. Otherwise all controls 0.
- div_start = 1 only in IDLE with div_req_EX=1, mem_busy_MEM=0 and flush_req=0. In that case next state is DIV_BUSY and counter loads DIV_CYCLES-1.
- DIV_BUSY:
  - Counter decrements every cycle, including while mem_busy_MEM=1, because the divider runs independently of the pipeline.
  - When counter==0, next state is DIV_DONE.
- DIV_DONE:
  - div_result_valid=1; no divide stall is issued.
  - Next state is IDLE when mem_busy_MEM=0. Otherwise stay in DIV_DONE: EX has not advanced, and the same div must not restart.
- Latency: div_start in cycle 0 → divide stall in cycles 0..DIV_CYCLES → div_result_valid in cycle DIV_CYCLES+1.
- A div_req_EX seen in IDLE while mem_busy_MEM=1 does not start the divider; it starts in the first cycle mem_busy_MEM=0.
- load_use_ID during a divide stall is absorbed: no is_zeros_ID_EX, because ID/EX is already held.
- Back-to-back divides: the second div reaches EX after DIV_DONE→IDLE and starts normally.

Optional Feature:
STALL_PERF_EN:
- Defined:
  - stall_cycles increments on every cycle with is_hold_IF=1.
  - flush_count increments on every cycle with flush_req=1.
  - Both counters saturate at all-ones, clear on perf_clr=1 at the clock edge, and reset to 0 on rst.
- Undefined: no counter flops; stall_cycles and flush_count are tied to 0 and perf_clr is ignored.

Test Plan:
- DIV_CYCLES=4, pulse div_req_EX high from cycle 0 → div_start=1 in cycle 0 only; is_hold_IF/IF_ID/ID_EX=1 and is_zeros_EX_MEM=1 in cycles 0..4; div_result_valid=1 in cycle 5; IDLE in cycle 6.
- load_use_ID=1 for 1 cycle in IDLE → is_hold_IF=1, is_hold_IF_ID=1, is_zeros_ID_EX=1 that cycle; all 0 the next cycle.
- mem_busy_MEM=1 for 3 cycles → four holds and is_zeros_MEM_WB=1 for exactly 3 cycles; with STALL_PERF_EN, stall_cycles=3.
- Divide in DIV_BUSY, counter=2, flush_req=1 → zeros on IF_ID/ID_EX/EX_MEM that cycle; next cycle state IDLE, no div_result_valid ever issued; flush_count=1.
- Reach DIV_DONE with mem_busy_MEM=1 for 2 cycles → div_result_valid held 3 cycles, no second div_start; IDLE after mem_busy_MEM drops.
- Assert rst mid-DIV_BUSY → all outputs 0 immediately (async); after release, div_req_EX=1 produces a fresh div_start.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Central stall/flush scheduler for the 5-stage MIPS pipeline. Merges four
// stall causes (exception flush, data-memory wait, multi-cycle divide,
// load-use hazard) into per-stage hold and bubble controls. It also sequences
// the iterative divider: a start pulse, a fixed-latency countdown and a
// result-valid strobe.
//
// Optional feature macro: STALL_PERF_EN
//   defined   -> saturating performance counters stall_cycles / flush_count
//   undefined -> counters tied to 0, perf_clr ignored
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush_req           exception/eret flush request from MEM
//   mem_busy_MEM        data memory not ready, MEM must wait
//   div_req_EX          level: a div/divu occupies EX
//   load_use_ID         load-use hazard for the instruction in ID
//   div_start           one-cycle divider start pulse
//   div_result_valid    divider result may be consumed by EX
//   is_hold_*           freeze PC / pipeline registers
//   is_zeros_*          load a bubble into pipeline registers
//   perf_clr            synchronous clear of the perf counters
//   stall_cycles        cycles with is_hold_IF asserted
//   flush_count         cycles with flush_req asserted
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_WIDTH  = 6,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  input  logic                  mem_busy_MEM,
  input  logic                  div_req_EX,
  input  logic                  load_use_ID,
  output logic                  div_start,
  output logic                  div_result_valid,
  output logic                  is_hold_IF,
  output logic                  is_hold_IF_ID,
  output logic                  is_hold_ID_EX,
  output logic                  is_hold_EX_MEM,
  output logic                  is_zeros_IF_ID,
  output logic                  is_zeros_ID_EX,
  output logic                  is_zeros_EX_MEM,
  output logic                  is_zeros_MEM_WB,
  input  logic                  perf_clr,
  output logic [PERF_WIDTH-1:0] stall_cycles,
  output logic [PERF_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 div_stall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the if/case tree leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    div_start        = 1'b0;
    div_result_valid = 1'b0;
    is_hold_IF       = 1'b0;
    is_hold_IF_ID    = 1'b0;
    is_hold_ID_EX    = 1'b0;
    is_hold_EX_MEM   = 1'b0;
    is_zeros_IF_ID   = 1'b0;
    is_zeros_ID_EX   = 1'b0;
    is_zeros_EX_MEM  = 1'b0;
    is_zeros_MEM_WB  = 1'b0;

    // A divide stalls while running, and from the very cycle the div reaches
    // EX in IDLE. DIV_DONE never stalls: EX may consume the result.
    div_stall = (state_q == DIV_BUSY) || ((state_q == IDLE) && div_req_EX);

    // Controls are combinational, so reset must force them quiet directly
    // rather than wait for the state flops.
    if (!rst) begin
      if (flush_req) begin
        is_zeros_IF_ID  = 1'b1;
        is_zeros_ID_EX  = 1'b1;
        is_zeros_EX_MEM = 1'b1;
      end else if (mem_busy_MEM) begin
        is_hold_IF      = 1'b1;
        is_hold_IF_ID   = 1'b1;
        is_hold_ID_EX   = 1'b1;
        is_hold_EX_MEM  = 1'b1;
        is_zeros_MEM_WB = 1'b1;
      end else if (div_stall) begin
        // A load-use hazard here is absorbed: ID/EX is already held.
        is_hold_IF      = 1'b1;
        is_hold_IF_ID   = 1'b1;
        is_hold_ID_EX   = 1'b1;
        is_zeros_EX_MEM = 1'b1;
      end else if (load_use_ID) begin
        is_hold_IF      = 1'b1;
        is_hold_IF_ID   = 1'b1;
        is_zeros_ID_EX  = 1'b1;
      end

      div_start        = !flush_req && !mem_busy_MEM && div_req_EX && (state_q == IDLE);
      div_result_valid = !flush_req && (state_q == DIV_DONE);
    end

    // Next state. A flush abandons any divide; the divider itself keeps
    // counting through memory waits because it runs independently of the pipe.
    if (flush_req) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (div_req_EX && !mem_busy_MEM) begin
            state_d = DIV_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        DIV_BUSY: begin
          if (cnt_q == '0) state_d = DIV_DONE;
          else             cnt_d   = cnt_q - CNT_WIDTH'(1);
        end
        DIV_DONE: begin
          // Holding here while MEM waits stops the same div from restarting.
          if (!mem_busy_MEM) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef STALL_PERF_EN
  logic [PERF_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (perf_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (is_hold_IF && (stall_q != '1)) stall_d = stall_q + PERF_WIDTH'(1);
      if (flush_req  && (flush_q != '1)) flush_d = flush_q + PERF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cycles    = '0;
  assign flush_count     = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Self-checking bench for pipeline_stall_ctrl with DIV_CYCLES=4. Each scenario
// drives one cycle of inputs, pushes the expected control vector to a
// scoreboard queue, and pops/compares it mid-cycle (on the falling edge).
// Control vector bit order:
//   {div_start, div_result_valid, hold_IF, hold_IF_ID, hold_ID_EX,
//    hold_EX_MEM, zeros_IF_ID, zeros_ID_EX, zeros_EX_MEM, zeros_MEM_WB}
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

  localparam int DIV_CYCLES = 4;
  localparam int CNT_WIDTH  = 6;
  localparam int PERF_WIDTH = 32;

  // Input encodings {flush_req, mem_busy_MEM, div_req_EX, load_use_ID}
  localparam logic [3:0] I_NO = 4'b0000;
  localparam logic [3:0] I_LU = 4'b0001;
  localparam logic [3:0] I_DV = 4'b0010;
  localparam logic [3:0] I_MB = 4'b0100;
  localparam logic [3:0] I_FL = 4'b1000;

  // Expected control patterns
  localparam logic [9:0] C_NONE  = 10'b00_0000_0000;
  localparam logic [9:0] C_START = 10'b10_0000_0000;
  localparam logic [9:0] C_VALID = 10'b01_0000_0000;
  localparam logic [9:0] C_DIV   = 10'b00_1110_0010;
  localparam logic [9:0] C_LU    = 10'b00_1100_0100;
  localparam logic [9:0] C_MB    = 10'b00_1111_0001;
  localparam logic [9:0] C_FL    = 10'b00_0000_1110;

  logic clk          = 1'b0;
  logic rst          = 1'b1;
  logic flush_req    = 1'b0;
  logic mem_busy_MEM = 1'b0;
  logic div_req_EX   = 1'b0;
  logic load_use_ID  = 1'b0;
  logic perf_clr     = 1'b0;

  logic div_start, div_result_valid;
  logic is_hold_IF, is_hold_IF_ID, is_hold_ID_EX, is_hold_EX_MEM;
  logic is_zeros_IF_ID, is_zeros_ID_EX, is_zeros_EX_MEM, is_zeros_MEM_WB;
  logic [PERF_WIDTH-1:0] stall_cycles, flush_count;

  logic [9:0] outs;
  assign outs = {div_start, div_result_valid, is_hold_IF, is_hold_IF_ID,
                 is_hold_ID_EX, is_hold_EX_MEM, is_zeros_IF_ID, is_zeros_ID_EX,
                 is_zeros_EX_MEM, is_zeros_MEM_WB};

  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_WIDTH (CNT_WIDTH),
    .PERF_WIDTH(PERF_WIDTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_req       (flush_req),
    .mem_busy_MEM    (mem_busy_MEM),
    .div_req_EX      (div_req_EX),
    .load_use_ID     (load_use_ID),
    .div_start       (div_start),
    .div_result_valid(div_result_valid),
    .is_hold_IF      (is_hold_IF),
    .is_hold_IF_ID   (is_hold_IF_ID),
    .is_hold_ID_EX   (is_hold_ID_EX),
    .is_hold_EX_MEM  (is_hold_EX_MEM),
    .is_zeros_IF_ID  (is_zeros_IF_ID),
    .is_zeros_ID_EX  (is_zeros_ID_EX),
    .is_zeros_EX_MEM (is_zeros_EX_MEM),
    .is_zeros_MEM_WB (is_zeros_MEM_WB),
    .perf_clr        (perf_clr),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  // Apply one cycle of inputs and record what the controls must be.
  task automatic drive(input logic [3:0] in, input logic [9:0] exp);
    {flush_req, mem_busy_MEM, div_req_EX, load_use_ID} = in;
    exp_q.push_back(exp);
  endtask

  task automatic clear_perf();
    drive(I_NO, C_NONE);
    perf_clr = 1'b1;
    @(posedge clk); #1;
    perf_clr = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    logic [9:0] e;
    #2;
    drive(I_NO, C_NONE);
    e = exp_q.pop_front(); n_checks++;
    if (outs !== e) begin n_fail++; $display("FAIL reset_idle: got %b want %b", outs, e); end
    n_checks++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
    // A div in EX during reset must not leak through the combinational controls.
    drive(I_DV, C_NONE);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (outs !== e) begin n_fail++; $display("FAIL reset_gated: got %b want %b", outs, e); end
    drive(I_NO, C_NONE);
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_div_latency();
    logic [13:0] tbl [7];
    logic [9:0]  e;
    tbl = '{{I_DV, C_START | C_DIV}, {I_DV, C_DIV}, {I_DV, C_DIV}, {I_DV, C_DIV},
            {I_DV, C_DIV}, {I_DV, C_VALID}, {I_NO, C_NONE}};
    foreach (tbl[i]) begin
      drive(tbl[i][13:10], tbl[i][9:0]);
      @(negedge clk);
      e = exp_q.pop_front(); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL div_latency c%0d: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [13:0] tbl [2];
    logic [9:0]  e;
    tbl = '{{I_LU, C_LU}, {I_NO, C_NONE}};
    foreach (tbl[i]) begin
      drive(tbl[i][13:10], tbl[i][9:0]);
      @(negedge clk);
      e = exp_q.pop_front(); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL load_use c%0d: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_busy();
    logic [13:0] tbl [4];
    logic [9:0]  e;
    logic [PERF_WIDTH-1:0] exp_stall;
    clear_perf();
    tbl = '{{I_MB, C_MB}, {I_MB, C_MB}, {I_MB, C_MB}, {I_NO, C_NONE}};
    foreach (tbl[i]) begin
      drive(tbl[i][13:10], tbl[i][9:0]);
      @(negedge clk);
      e = exp_q.pop_front(); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL mem_busy c%0d: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
`ifdef STALL_PERF_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    n_checks++;
    if (stall_cycles !== exp_stall) begin
      n_fail++; $display("FAIL mem_busy_stall_cycles: got %0d want %0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_flush_mid_div();
    logic [13:0] tbl [8];
    logic [9:0]  e;
    logic [PERF_WIDTH-1:0] exp_stall, exp_flush;
    clear_perf();
    // Flush lands in DIV_BUSY with the counter at 2; no result may follow.
    tbl = '{{I_DV, C_START | C_DIV}, {I_DV, C_DIV}, {I_FL | I_DV, C_FL},
            {I_NO, C_NONE}, {I_NO, C_NONE}, {I_NO, C_NONE}, {I_NO, C_NONE}, {I_NO, C_NONE}};
    foreach (tbl[i]) begin
      drive(tbl[i][13:10], tbl[i][9:0]);
      @(negedge clk);
      e = exp_q.pop_front(); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL flush_mid_div c%0d: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
`ifdef STALL_PERF_EN
    exp_stall = 2;
    exp_flush = 1;
`else
    exp_stall = 0;
    exp_flush = 0;
`endif
    n_checks++;
    if (flush_count !== exp_flush) begin
      n_fail++; $display("FAIL flush_count: got %0d want %0d", flush_count, exp_flush);
    end
    n_checks++;
    if (stall_cycles !== exp_stall) begin
      n_fail++; $display("FAIL flush_stall_cycles: got %0d want %0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_done_mem_busy();
    logic [13:0] tbl [9];
    logic [9:0]  e;
    tbl = '{{I_DV, C_START | C_DIV}, {I_DV, C_DIV}, {I_DV, C_DIV}, {I_DV, C_DIV},
            {I_DV, C_DIV}, {I_MB | I_DV, C_VALID | C_MB}, {I_MB | I_DV, C_VALID | C_MB},
            {I_DV, C_VALID}, {I_NO, C_NONE}};
    foreach (tbl[i]) begin
      drive(tbl[i][13:10], tbl[i][9:0]);
      @(negedge clk);
      e = exp_q.pop_front(); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL done_mem_busy c%0d: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_deferred_start();
    logic [13:0] tbl [8];
    logic [9:0]  e;
    tbl = '{{I_MB | I_DV, C_MB}, {I_DV, C_START | C_DIV}, {I_DV, C_DIV}, {I_DV, C_DIV},
            {I_DV, C_DIV}, {I_DV, C_DIV}, {I_DV, C_VALID}, {I_NO, C_NONE}};
    foreach (tbl[i]) begin
      drive(tbl[i][13:10], tbl[i][9:0]);
      @(negedge clk);
      e = exp_q.pop_front(); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL deferred_start c%0d: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] tbl [13];
    logic [9:0]  e;
    // Load-use during the first divide is absorbed; the second div starts
    // right after DIV_DONE -> IDLE.
    tbl = '{{I_DV, C_START | C_DIV}, {I_DV, C_DIV}, {I_DV | I_LU, C_DIV}, {I_DV, C_DIV},
            {I_DV, C_DIV}, {I_DV, C_VALID}, {I_DV, C_START | C_DIV}, {I_DV, C_DIV},
            {I_DV, C_DIV}, {I_DV, C_DIV}, {I_DV, C_DIV}, {I_DV, C_VALID}, {I_NO, C_NONE}};
    foreach (tbl[i]) begin
      drive(tbl[i][13:10], tbl[i][9:0]);
      @(negedge clk);
      e = exp_q.pop_front(); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL back_to_back c%0d: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    logic [13:0] tbl [7];
    logic [9:0]  e;
    drive(I_DV, C_START | C_DIV);
    @(negedge clk);
    e = exp_q.pop_front(); n_checks++;
    if (outs !== e) begin n_fail++; $display("FAIL async_reset_pre: got %b want %b", outs, e); end
    @(posedge clk); #1;
    // Mid-divide: reset between clock edges must silence everything at once.
    drive(I_DV, C_NONE);
    #1 rst = 1'b1;
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (outs !== e) begin n_fail++; $display("FAIL async_reset_now: got %b want %b", outs, e); end
    @(posedge clk); #1;
    rst = 1'b0;
    tbl = '{{I_DV, C_START | C_DIV}, {I_DV, C_DIV}, {I_DV, C_DIV}, {I_DV, C_DIV},
            {I_DV, C_DIV}, {I_DV, C_VALID}, {I_NO, C_NONE}};
    foreach (tbl[i]) begin
      drive(tbl[i][13:10], tbl[i][9:0]);
      @(negedge clk);
      e = exp_q.pop_front(); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL async_reset_post c%0d: got %b want %b", i, outs, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_div_latency();
    test_load_use();
    test_mem_busy();
    test_flush_mid_div();
    test_done_mem_busy();
    test_deferred_start();
    test_back_to_back();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
